// File: rtl/irrigacao_pkg.sv
// Shared definitions for the irrigation actuator sequencer.
// Holds the sequencer state codes (also exported on ESTADO for debug)
// and the two watering mode constants.
package irrigacao_pkg;

  // State codes are fixed because ESTADO exposes them directly.
  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ABRINDO  = 3'd1,
    REGANDO  = 3'd2,
    FECHANDO = 3'd3,
    PAUSA    = 3'd4,
    FALHA    = 3'd5
  } estado_t;

  // Watering mode: sprinkler uses the pump, drip runs by gravity.
  localparam logic MODO_ASP = 1'b0;
  localparam logic MODO_GOT = 1'b1;

endpackage

// File: rtl/irrigacao_temporizador.sv
// Saturating cycle counter used to time every sequencer state.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset, clears the count
//   clr - synchronous clear, takes priority over counting
//   en  - count enable
//   cnt - current count, holds at all-ones instead of wrapping
module irrigacao_temporizador #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);

  // Clearing wins over counting so a state change always restarts at 0;
  // saturation keeps a long stay from wrapping back into small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/irrigacao_sequenciador.sv
// Actuator sequencer for the irrigation controller.
// Turns the sprinkler (Bs) and drip (Vs) run requests into a safe timed
// sequence: valve opens, pump runs (sprinkler only), pump stops, valve
// closes, then a rest period. A run that lasts too long latches a fault.
// Ports:
//   CLK      - rising-edge clock
//   RST      - synchronous active-high reset
//   Bs, Vs   - sprinkler / drip run request levels
//   LIMPA    - clears a latched fault while in FALHA
//   BOMBA    - pump enable
//   VALV_ASP - sprinkler valve open
//   VALV_GOT - drip valve open
//   ATIVO    - sequencer busy (not OCIOSO)
//   ERRO     - sticky timeout fault
//   ESTADO   - current state code
module irrigacao_sequenciador
  import irrigacao_pkg::*;
#(
  parameter int unsigned T_ABRE  = 4,
  parameter int unsigned T_MIN   = 8,
  parameter int unsigned T_MAX   = 64,
  parameter int unsigned T_PAUSA = 8,
  parameter int unsigned CW      = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Bs,
  input  logic       Vs,
  input  logic       LIMPA,
  output logic       BOMBA,
  output logic       VALV_ASP,
  output logic       VALV_GOT,
  output logic       ATIVO,
  output logic       ERRO,
  output logic [2:0] ESTADO
);

  localparam logic [CW-1:0] ABRE_FIM  = CW'(T_ABRE - 1);
  localparam logic [CW-1:0] MIN_FIM   = CW'(T_MIN - 1);
  localparam logic [CW-1:0] MAX_FIM   = CW'(T_MAX - 1);
  localparam logic [CW-1:0] PAUSA_FIM = CW'(T_PAUSA - 1);

  estado_t       estado;
  estado_t       estado_next;
  logic          modo;
  logic          modo_next;
  logic          erro;
  logic          erro_next;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          req;
  logic          valvula_aberta;

  // The counter restarts on every state change, so cnt is always
  // "cycles spent in the current state".
  assign cnt_clr = (estado_next != estado);

  irrigacao_temporizador #(
    .CW (CW)
  ) u_temporizador (
    .clk (CLK),
    .rst (RST),
    .clr (cnt_clr),
    .en  (1'b1),
    .cnt (cnt)
  );

  // A request for the other mode is treated as the current run's request
  // going away, so a mode switch always goes through a full shutdown.
  assign req = modo ? (Vs & ~Bs) : (Bs & ~Vs);

  // State, mode and fault registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      estado <= OCIOSO;
      modo   <= MODO_ASP;
      erro   <= 1'b0;
    end else begin
      estado <= estado_next;
      modo   <= modo_next;
      erro   <= erro_next;
    end
  end

  // Next-state logic. The timeout check in REGANDO is tested before the
  // normal stop so a run can never extend past T_MAX cycles; a request
  // dropped early is simply not acted on until T_MIN cycles have passed.
  always_comb begin
    estado_next = estado;
    modo_next   = modo;
    erro_next   = erro;
    case (estado)
      OCIOSO: begin
        if (Bs ^ Vs) begin
          estado_next = ABRINDO;
          modo_next   = Vs ? MODO_GOT : MODO_ASP;
        end
      end
      ABRINDO: begin
        if (cnt == ABRE_FIM) begin
          estado_next = REGANDO;
        end
      end
      REGANDO: begin
        if (cnt == MAX_FIM) begin
          erro_next   = 1'b1;
          estado_next = FECHANDO;
        end else if (!req && (cnt >= MIN_FIM)) begin
          estado_next = FECHANDO;
        end
      end
      FECHANDO: begin
        if (cnt == ABRE_FIM) begin
          estado_next = erro ? FALHA : PAUSA;
        end
      end
      PAUSA: begin
        if (cnt == PAUSA_FIM) begin
          estado_next = OCIOSO;
        end
      end
      FALHA: begin
        if (LIMPA) begin
          erro_next   = 1'b0;
          estado_next = PAUSA;
        end
      end
      default: begin
        estado_next = OCIOSO;
      end
    endcase
  end

  // Moore output decode from the registered state and mode only, so no
  // input can reach an actuator combinationally. Only the valve of the
  // latched mode ever opens, which keeps the two valves exclusive.
  always_comb begin
    valvula_aberta = 1'b0;
    BOMBA          = 1'b0;
    VALV_ASP       = 1'b0;
    VALV_GOT       = 1'b0;
    ATIVO          = 1'b0;
    case (estado)
      ABRINDO, FECHANDO: begin
        valvula_aberta = 1'b1;
        ATIVO          = 1'b1;
      end
      REGANDO: begin
        valvula_aberta = 1'b1;
        ATIVO          = 1'b1;
        BOMBA          = (modo == MODO_ASP);
      end
      PAUSA, FALHA: begin
        ATIVO = 1'b1;
      end
      OCIOSO: begin
        ATIVO = 1'b0;
      end
      default: begin
        ATIVO = 1'b1;
      end
    endcase
    VALV_ASP = valvula_aberta && (modo == MODO_ASP);
    VALV_GOT = valvula_aberta && (modo == MODO_GOT);
  end

  assign ERRO   = erro;
  assign ESTADO = estado;

endmodule

// File: tb/tb_irrigacao_sequenciador.sv
// Self-checking bench for irrigacao_sequenciador with default parameters.
// A phase/age reference model tracks the expected sequence every cycle;
// directed scenarios add run-length totals derived from the timing rules.
module tb_irrigacao_sequenciador;

  localparam int T_ABRE  = 4;
  localparam int T_MIN   = 8;
  localparam int T_MAX   = 64;
  localparam int T_PAUSA = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Bs;
  logic       Vs;
  logic       LIMPA;
  logic       BOMBA;
  logic       VALV_ASP;
  logic       VALV_GOT;
  logic       ATIVO;
  logic       ERRO;
  logic [2:0] ESTADO;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: phase number, cycles spent in the phase, mode, fault.
  int mPhase = 0;
  int mAge   = 0;
  bit mDrip  = 0;
  bit mFault = 0;

  // Per-scenario tallies of actuator-on cycles.
  int pumpCycles;
  int aspCycles;
  int gotCycles;

  irrigacao_sequenciador dut (
    .CLK      (CLK),
    .RST      (RST),
    .Bs       (Bs),
    .Vs       (Vs),
    .LIMPA    (LIMPA),
    .BOMBA    (BOMBA),
    .VALV_ASP (VALV_ASP),
    .VALV_GOT (VALV_GOT),
    .ATIVO    (ATIVO),
    .ERRO     (ERRO),
    .ESTADO   (ESTADO)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic modelStep(input bit r, input bit b, input bit v, input bit l);
    int  next;
    bit  wants;
    if (r) begin
      mPhase = 0; mAge = 0; mDrip = 0; mFault = 0;
      return;
    end
    next = mPhase;
    case (mPhase)
      0: if (b != v) begin next = 1; mDrip = v; end
      1: if (mAge + 1 >= T_ABRE) next = 2;
      2: begin
        wants = mDrip ? (v && !b) : (b && !v);
        if (mAge + 1 >= T_MAX) begin mFault = 1; next = 3; end
        else if (!wants && mAge + 1 >= T_MIN) next = 3;
      end
      3: if (mAge + 1 >= T_ABRE) next = mFault ? 5 : 4;
      4: if (mAge + 1 >= T_PAUSA) next = 0;
      5: if (l) begin mFault = 0; next = 4; end
      default: next = 0;
    endcase
    if (next != mPhase) begin
      mPhase = next;
      mAge   = 0;
    end else if (mAge < 255) begin
      mAge++;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic applyStimulus(input bit r, input bit b, input bit v, input bit l);
    bit valveOpen;
    RST = r; Bs = b; Vs = v; LIMPA = l;
    @(posedge CLK);
    #1;
    modelStep(r, b, v, l);
    valveOpen = (mPhase >= 1) && (mPhase <= 3);
    checkOutput("ESTADO",   int'(ESTADO),   mPhase);
    checkOutput("VALV_ASP", int'(VALV_ASP), int'(valveOpen && !mDrip));
    checkOutput("VALV_GOT", int'(VALV_GOT), int'(valveOpen && mDrip));
    checkOutput("BOMBA",    int'(BOMBA),    int'(mPhase == 2 && !mDrip));
    checkOutput("ATIVO",    int'(ATIVO),    int'(mPhase != 0));
    checkOutput("ERRO",     int'(ERRO),     int'(mFault));
    pumpCycles += int'(BOMBA);
    aspCycles  += int'(VALV_ASP);
    gotCycles  += int'(VALV_GOT);
  endtask

  task automatic clearTallies();
    pumpCycles = 0; aspCycles = 0; gotCycles = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
  endtask

  initial begin
    bit rb, rv;

    // Reset state.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    idle(2);

    // Sprinkler run: Bs high for 20 cycles.
    clearTallies();
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0);
    idle(40);
    checkOutput("asp_valve_cycles", aspCycles, T_ABRE + 16 + T_ABRE);
    checkOutput("asp_pump_cycles", pumpCycles, 16);

    // Short drip request: minimum run, no pump.
    clearTallies();
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0);
    idle(40);
    checkOutput("got_valve_cycles", gotCycles, T_ABRE + T_MIN + T_ABRE);
    checkOutput("got_pump_cycles", pumpCycles, 0);

    // Conflict: both requests high keeps the block idle.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0);
    checkOutput("conflict_estado", int'(ESTADO), 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("conflict_release_asp", int'(VALV_ASP), 1);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0);
    idle(30);

    // Timeout: Bs held, fault latched, cleared by a LIMPA pulse.
    clearTallies();
    for (int i = 0; i < 80; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("timeout_pump_cycles", pumpCycles, T_MAX);
    checkOutput("timeout_estado", int'(ESTADO), 5);
    checkOutput("timeout_erro", int'(ERRO), 1);
    idle(3);
    applyStimulus(0, 0, 0, 1);
    checkOutput("limpa_erro", int'(ERRO), 0);
    idle(T_PAUSA + 2);
    checkOutput("limpa_back_idle", int'(ESTADO), 0);

    // Mode switch mid-run: sprinkler shuts down, drip waits for PAUSA.
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 0);
    clearTallies();
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("switch_got_opened", int'(gotCycles > 0), 1);
    idle(40);

    // Reset mid-run during REGANDO.
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("rst_estado", int'(ESTADO), 0);
    checkOutput("rst_actuators", int'({BOMBA, VALV_ASP, VALV_GOT, ATIVO, ERRO}), 0);
    idle(3);

    // Randomized stretch with sticky request levels and rare LIMPA/RST.
    rb = 0; rv = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) rb = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 11) == 0) rv = $urandom_range(0, 1) != 0;
      applyStimulus($urandom_range(0, 399) == 0, rb, rv, $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
